tm1638_responder: RTL and testbench

- Device-side model of the TM1638 LED/key board: the other end of the 3-wire STB/CLK/DIO link driven by the AUDIO_OSC LED/key driver.
- Receives host commands and display data into a 16-byte display RAM plus display-control register.
- Answers key-read commands by driving 4 key bytes onto DIO.
- Used as a loopback target for the driver on CQ MAX10-FB spare pins, and as the bench responder for driver verification.

---
 rtl/tm1638_pkg.sv | 32 +++
 rtl/tm1638_responder_if.sv | 34 +++
 rtl/tm1638_edge_sync.sv | 58 +++++
 rtl/tm1638_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_tm1638_responder.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 device-side responder.
// Holds the command-class codes carried in bits [7:6] of the first byte of
// a frame, the data-command flag positions, the display RAM geometry and
// the frame FSM state encoding.
package tm1638_pkg;

    // Command class, taken from bits [7:6] of the first byte in a frame
    localparam logic [1:0] DATA = 2'b01;
    localparam logic [1:0] DISP = 2'b10;
    localparam logic [1:0] ADDR = 2'b11;

    // Flag positions inside a data command
    localparam int RD_BIT  = 1;
    localparam int FIX_BIT = 2;

    // Display RAM geometry
    localparam int RAM_DEPTH = 16;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR,
        RD,
        SKIP
    } state_t;

    function automatic logic [1:0] cmd_class(input logic [7:0] cmd_byte);
        return cmd_byte[7:6];
    endfunction

endpackage

// File: rtl/tm1638_responder_if.sv
// Three-wire TM1638 link (STB / CLK / DIO) as seen at the board pins.
// DIO is split into the pad input and the device drive value plus enable,
// so the bidirectional pad buffer lives outside this block.
//   STB_i    - host strobe, active low
//   SCLK_i   - host serial clock, idles high
//   DIO_i    - DIO pad value seen by the device
//   DIO_o    - value the device drives onto DIO
//   DIO_OE_o - device output enable for DIO
// Modports: master = host side, slave = device side.
interface tm1638_responder_if;

    logic STB_i;
    logic SCLK_i;
    logic DIO_i;
    logic DIO_o;
    logic DIO_OE_o;

    modport master (
        output STB_i,
        output SCLK_i,
        output DIO_i,
        input  DIO_o,
        input  DIO_OE_o
    );

    modport slave (
        input  STB_i,
        input  SCLK_i,
        input  DIO_i,
        output DIO_o,
        output DIO_OE_o
    );

endinterface

// File: rtl/tm1638_edge_sync.sv
// Input conditioning for the TM1638 link.
// STB, SCLK and DIO share one multi-stage synchronizer chain; STB and SCLK
// then go through an edge detector that compares the synced value with a
// one-cycle delayed copy.
//   clk, rst_n, en         - system clock, async active-low reset, clock enable
//   stb_pad/sclk_pad/dio_pad - raw pad inputs
//   stb, dio               - synced levels
//   stb_fall               - synced STB falling edge (frame start)
//   sclk_rise, sclk_fall   - synced SCLK edges
module tm1638_edge_sync #(
    parameter int C_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic stb_pad,
    input  logic sclk_pad,
    input  logic dio_pad,
    output logic stb,
    output logic stb_fall,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic dio
);

    // Fewer than two stages is not a safe synchronizer, so clamp upwards
    localparam int STAGES = (C_SYNC_STAGES < 2) ? 2 : C_SYNC_STAGES;

    // Element [0] of each stage is STB, [1] is SCLK, [2] is DIO
    logic [STAGES-1:0][2:0] chain;
    logic [2:0]             synced;
    logic                   stb_d;
    logic                   sclk_d;

    assign synced = chain[STAGES-1];

    // Everything resets low. A low synced STB after reset means a frame that
    // was already running when reset hit never produces a falling edge, so it
    // is ignored until the host raises and lowers STB again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain  <= '0;
            stb_d  <= 1'b0;
            sclk_d <= 1'b0;
        end else if (en) begin
            chain  <= {chain[STAGES-2:0], {dio_pad, sclk_pad, stb_pad}};
            stb_d  <= synced[0];
            sclk_d <= synced[1];
        end
    end

    assign stb       = synced[0];
    assign stb_fall  = ~synced[0] & stb_d;
    assign sclk_rise = synced[1] & ~sclk_d;
    assign sclk_fall = ~synced[1] & sclk_d;
    assign dio       = synced[2];

endmodule

// File: rtl/tm1638_responder.sv
// Device-side model of a TM1638 LED/key board.
// Receives host commands and display data over the STB/CLK/DIO link into a
// 16-byte display RAM plus display-control register, and answers key-read
// commands by shifting four key bytes out on DIO, LSB first.
//   CK_i       - system clock
//   XARST_i    - asynchronous active-low reset
//   EN_CK_i    - clock enable, all state holds while low
//   link       - STB/CLK/DIO link, device side
//   KEY_i      - key matrix, byte n returned as read byte n
//   DISP_RAM_o - display RAM, address a at bits [8a+7:8a]
//   DISP_ON_o  - display enable from the display-control command
//   BRIGHT_o   - brightness from the display-control command
//   WR_STB_o   - one-cycle pulse per RAM byte written
//   WR_ADR_o   - address of the last RAM write
//   WR_DAT_o   - data of the last RAM write
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int C_SYNC_STAGES = 2
) (
    input  logic                        CK_i,
    input  logic                        XARST_i,
    input  logic                        EN_CK_i,
    tm1638_responder_if.slave           link,
    input  logic [31:0]                 KEY_i,
    output logic [RAM_DEPTH*8-1:0]      DISP_RAM_o,
    output logic                        DISP_ON_o,
    output logic [2:0]                  BRIGHT_o,
    output logic                        WR_STB_o,
    output logic [RAM_AW-1:0]           WR_ADR_o,
    output logic [7:0]                  WR_DAT_o
);

    logic stb;
    logic stb_fall;
    logic sclk_rise;
    logic sclk_fall;
    logic dio;

    state_t state;
    state_t state_next;

    logic [2:0]                  bit_cnt;
    logic [7:0]                  shift_reg;
    logic [7:0]                  rx_byte;
    logic                        byte_done;

    logic                        do_data;
    logic                        do_disp;
    logic                        do_addr;
    logic                        do_write;

    logic [RAM_AW-1:0]           ptr;
    logic                        fixed_mode;
    logic [RAM_DEPTH-1:0][7:0]   ram;
    logic                        disp_on;
    logic [2:0]                  bright;
    logic                        wr_stb;
    logic [RAM_AW-1:0]           wr_adr;
    logic [7:0]                  wr_dat;

    logic [31:0]                 key_sh;
    logic                        dio_q;
    logic                        oe_q;

    tm1638_edge_sync #(
        .C_SYNC_STAGES (C_SYNC_STAGES)
    ) u_edge_sync (
        .clk       (CK_i),
        .rst_n     (XARST_i),
        .en        (EN_CK_i),
        .stb_pad   (link.STB_i),
        .sclk_pad  (link.SCLK_i),
        .dio_pad   (link.DIO_i),
        .stb       (stb),
        .stb_fall  (stb_fall),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .dio       (dio)
    );

    // Bits arrive LSB first and enter at the top, so on the 8th rise the
    // incoming bit plus the upper seven shifted bits form the whole byte.
    assign rx_byte   = {dio, shift_reg[7:1]};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    // State register
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state <= IDLE;
        end else if (EN_CK_i) begin
            state <= state_next;
        end
    end

    // Next-state decode. STB high overrides everything, which also makes a
    // STB rise win over an SCLK rise seen in the same cycle.
    always_comb begin
        state_next = state;
        do_data    = 1'b0;
        do_disp    = 1'b0;
        do_addr    = 1'b0;
        do_write   = 1'b0;
        if (stb) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (stb_fall) begin
                        state_next = CMD;
                    end
                end
                CMD: begin
                    if (byte_done) begin
                        case (cmd_class(rx_byte))
                            DATA: begin
                                do_data    = 1'b1;
                                state_next = rx_byte[RD_BIT] ? RD : SKIP;
                            end
                            DISP: begin
                                do_disp    = 1'b1;
                                state_next = SKIP;
                            end
                            ADDR: begin
                                do_addr    = 1'b1;
                                state_next = WR;
                            end
                            default: begin
                                state_next = SKIP;
                            end
                        endcase
                    end
                end
                WR: begin
                    if (byte_done) begin
                        do_write = 1'b1;
                    end
                end
                RD, SKIP: begin
                    state_next = state;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Byte assembly. The counter is held at zero outside a frame so a
    // partial byte cut off by STB never leaks into the next frame.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            bit_cnt   <= 3'd0;
            shift_reg <= 8'd0;
        end else if (EN_CK_i) begin
            if (stb || state == IDLE) begin
                bit_cnt <= 3'd0;
            end else if ((state == CMD || state == WR) && sclk_rise) begin
                shift_reg <= rx_byte;
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    // Command side effects: addressing mode, display control and the RAM
    // pointer. Fixed mode persists across frames until the next data command.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            fixed_mode <= 1'b0;
            disp_on    <= 1'b0;
            bright     <= 3'd0;
            ptr        <= '0;
        end else if (EN_CK_i) begin
            if (do_data) begin
                fixed_mode <= rx_byte[FIX_BIT];
            end
            if (do_disp) begin
                disp_on <= rx_byte[3];
                bright  <= rx_byte[2:0];
            end
            if (do_addr) begin
                ptr <= rx_byte[RAM_AW-1:0];
            end else if (do_write && !fixed_mode) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // Display RAM and the write notification, registered together so the
    // strobe, address and data are valid in the same cycle.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            ram    <= '0;
            wr_stb <= 1'b0;
            wr_adr <= '0;
            wr_dat <= 8'd0;
        end else if (EN_CK_i) begin
            wr_stb <= do_write;
            if (do_write) begin
                ram[ptr] <= rx_byte;
                wr_adr   <= ptr;
                wr_dat   <= rx_byte;
            end
        end
    end

    // Key readback. Keys are captured when the read command completes and
    // shifted out one bit per SCLK fall. Zeros are shifted in behind, so once
    // all 32 bits are out DIO keeps driving 0 until STB rises.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            key_sh <= 32'd0;
            dio_q  <= 1'b0;
            oe_q   <= 1'b0;
        end else if (EN_CK_i) begin
            if (stb) begin
                dio_q <= 1'b0;
                oe_q  <= 1'b0;
            end else if (do_data && rx_byte[RD_BIT]) begin
                key_sh <= KEY_i;
            end else if (state == RD && sclk_fall) begin
                oe_q   <= 1'b1;
                dio_q  <= key_sh[0];
                key_sh <= {1'b0, key_sh[31:1]};
            end
        end
    end

    // The enable is gated by the synced STB level so the pad is released in
    // the same cycle STB high is seen, not one cycle later.
    assign link.DIO_OE_o = oe_q & ~stb;
    assign link.DIO_o    = dio_q;

    assign DISP_RAM_o = ram;
    assign DISP_ON_o  = disp_on;
    assign BRIGHT_o   = bright;
    assign WR_STB_o   = wr_stb;
    assign WR_ADR_o   = wr_adr;
    assign WR_DAT_o   = wr_dat;

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder acting as the host on the TM1638 link.
// Expected RAM writes and key bytes are queued when frames are driven and
// popped when the device produces them.
module tb_tm1638_responder;

    localparam int H = 26;

    logic          CK_i = 1'b0;
    logic          XARST_i;
    logic          EN_CK_i;
    logic [31:0]   KEY_i;
    logic [127:0]  DISP_RAM_o;
    logic          DISP_ON_o;
    logic [2:0]    BRIGHT_o;
    logic          WR_STB_o;
    logic [3:0]    WR_ADR_o;
    logic [7:0]    WR_DAT_o;

    typedef struct packed {
        logic [3:0] adr;
        logic [7:0] dat;
    } wr_t;

    wr_t              wr_q[$];
    logic [7:0]       rd_q[$];
    logic [7:0]       frame_q[$];
    logic [15:0][7:0] exp_ram;
    wr_t              exp_wr;

    int checks = 0;
    int errors = 0;

    tm1638_responder_if link();

    tm1638_responder #(
        .C_SYNC_STAGES (2)
    ) dut (
        .CK_i       (CK_i),
        .XARST_i    (XARST_i),
        .EN_CK_i    (EN_CK_i),
        .link       (link),
        .KEY_i      (KEY_i),
        .DISP_RAM_o (DISP_RAM_o),
        .DISP_ON_o  (DISP_ON_o),
        .BRIGHT_o   (BRIGHT_o),
        .WR_STB_o   (WR_STB_o),
        .WR_ADR_o   (WR_ADR_o),
        .WR_DAT_o   (WR_DAT_o)
    );

    always #5 CK_i = ~CK_i;

    // Single comparison point: counts the check, reports tag/observed/expected
    task automatic checkOutput(input string tag, input logic [127:0] obs,
                               input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitCk(input int n);
        repeat (n) @(posedge CK_i);
        #1;
    endtask

    task automatic sendBits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            link.SCLK_i = 1'b0;
            link.DIO_i  = b[i];
            waitCk(H);
            link.SCLK_i = 1'b1;
            waitCk(H);
        end
    endtask

    // Drives one complete frame made of the bytes in frame_q
    task automatic applyStimulus();
        link.STB_i = 1'b0;
        waitCk(H);
        foreach (frame_q[i]) begin
            sendBits(frame_q[i], 8);
        end
        link.STB_i = 1'b1;
        waitCk(2 * H);
    endtask

    // Clocks n key bytes back from the device, checking OE on every bit
    task automatic readKeys(input int n);
        logic [7:0] got;
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            got = 8'd0;
            for (int i = 0; i < 8; i++) begin
                link.SCLK_i = 1'b0;
                waitCk(H);
                got[i] = link.DIO_o;
                checkOutput("dio_oe_reading", 128'(link.DIO_OE_o), 128'd1);
                link.SCLK_i = 1'b1;
                waitCk(H);
            end
            exp = rd_q.pop_front();
            checkOutput("key_byte", 128'(got), 128'(exp));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ram"}, DISP_RAM_o, 128'd0);
        checkOutput({tag, "_ctrl"},
                    128'({DISP_ON_o, BRIGHT_o, WR_STB_o, WR_ADR_o, WR_DAT_o}),
                    128'd0);
        checkOutput({tag, "_dio"}, 128'({link.DIO_o, link.DIO_OE_o}), 128'd0);
    endtask

    // Write scoreboard: every WR_STB_o cycle must match the oldest queued write
    always @(negedge CK_i) begin
        if (WR_STB_o === 1'b1) begin
            checkOutput("wr_expected", 128'(wr_q.size() > 0), 128'd1);
            if (wr_q.size() > 0) begin
                exp_wr = wr_q.pop_front();
                checkOutput("wr_adr_dat", 128'({WR_ADR_o, WR_DAT_o}),
                            128'({exp_wr.adr, exp_wr.dat}));
            end
        end
    end

    initial begin
        XARST_i     = 1'b0;
        EN_CK_i     = 1'b1;
        KEY_i       = 32'd0;
        link.STB_i  = 1'b1;
        link.SCLK_i = 1'b1;
        link.DIO_i  = 1'b1;
        exp_ram     = '0;

        waitCk(5);
        checkAllZero("reset");
        XARST_i = 1'b1;
        waitCk(10);
        checkAllZero("after_release");

        // Auto-increment fill of the whole RAM
        $display("[TB] sequential fill");
        frame_q = '{8'h40};
        applyStimulus();
        frame_q = '{8'hC0};
        for (int a = 0; a < 16; a++) begin
            frame_q.push_back(8'(a));
            wr_q.push_back('{adr: 4'(a), dat: 8'(a)});
            exp_ram[a] = 8'(a);
        end
        applyStimulus();
        checkOutput("fill_ram", DISP_RAM_o,
                    128'h0F0E0D0C0B0A09080706050403020100);
        checkOutput("fill_writes_done", 128'(wr_q.size()), 128'd0);

        // Fixed addressing
        $display("[TB] fixed address");
        frame_q = '{8'h44};
        applyStimulus();
        frame_q = '{8'hCE, 8'hAA, 8'h55};
        wr_q.push_back('{adr: 4'd14, dat: 8'hAA});
        wr_q.push_back('{adr: 4'd14, dat: 8'h55});
        exp_ram[14] = 8'h55;
        applyStimulus();
        checkOutput("fixed_ram", DISP_RAM_o, exp_ram);

        // Pointer wrap 15 -> 0, with write latency check on the first byte
        $display("[TB] pointer wrap");
        frame_q = '{8'h40};
        applyStimulus();
        wr_q.push_back('{adr: 4'd15, dat: 8'h11});
        wr_q.push_back('{adr: 4'd0,  dat: 8'h22});
        link.STB_i = 1'b0;
        waitCk(H);
        sendBits(8'hCF, 8);
        sendBits(8'h11, 7);
        link.SCLK_i = 1'b0;
        link.DIO_i  = 1'b0;
        waitCk(H);
        link.SCLK_i = 1'b1;
        repeat (3) @(negedge CK_i);
        checkOutput("latency_not_early", 128'(DISP_RAM_o[127:120]), 128'h0F);
        repeat (2) @(negedge CK_i);
        checkOutput("latency_visible", 128'(DISP_RAM_o[127:120]), 128'h11);
        waitCk(H - 5);
        sendBits(8'h22, 8);
        link.STB_i = 1'b1;
        waitCk(2 * H);
        exp_ram[15] = 8'h11;
        exp_ram[0]  = 8'h22;
        checkOutput("wrap_ram", DISP_RAM_o, exp_ram);

        // Display control
        $display("[TB] display control");
        frame_q = '{8'h8C};
        applyStimulus();
        checkOutput("disp_on_8c", 128'({DISP_ON_o, BRIGHT_o}), 128'h0C);
        checkOutput("disp_ram_kept_8c", DISP_RAM_o, exp_ram);
        frame_q = '{8'h80};
        applyStimulus();
        checkOutput("disp_off_80", 128'({DISP_ON_o, BRIGHT_o}), 128'h00);
        checkOutput("disp_ram_kept_80", DISP_RAM_o, exp_ram);

        // Key read of all four bytes plus one extra clock
        $display("[TB] key read");
        KEY_i = 32'h8421_F00F;
        rd_q.push_back(8'h0F);
        rd_q.push_back(8'hF0);
        rd_q.push_back(8'h21);
        rd_q.push_back(8'h84);
        link.STB_i = 1'b0;
        waitCk(H);
        sendBits(8'h42, 8);
        KEY_i = 32'hDEAD_BEEF;
        checkOutput("oe_before_first_fall", 128'(link.DIO_OE_o), 128'd0);
        readKeys(4);
        link.SCLK_i = 1'b0;
        waitCk(H);
        checkOutput("dio_after_32_bits", 128'({link.DIO_OE_o, link.DIO_o}), 128'b10);
        link.SCLK_i = 1'b1;
        waitCk(H);
        link.STB_i = 1'b1;
        waitCk(4);
        checkOutput("oe_after_stb_rise", 128'(link.DIO_OE_o), 128'd0);
        waitCk(2 * H);

        // Partial byte cut by STB must not write
        $display("[TB] partial byte");
        link.STB_i = 1'b0;
        waitCk(H);
        sendBits(8'hC3, 8);
        sendBits(8'h1F, 5);
        link.STB_i = 1'b1;
        waitCk(2 * H);
        frame_q = '{8'hC3, 8'h77};
        wr_q.push_back('{adr: 4'd3, dat: 8'h77});
        exp_ram[3] = 8'h77;
        applyStimulus();
        checkOutput("partial_ram", DISP_RAM_o, exp_ram);
        checkOutput("partial_writes_done", 128'(wr_q.size()), 128'd0);

        // Reset in the middle of a write frame
        $display("[TB] reset mid-write");
        frame_q = '{8'h8F};
        applyStimulus();
        checkOutput("disp_on_8f", 128'({DISP_ON_o, BRIGHT_o}), 128'h0F);
        link.STB_i = 1'b0;
        waitCk(H);
        sendBits(8'hC5, 8);
        sendBits(8'h04, 4);
        XARST_i = 1'b0;
        #1;
        checkAllZero("reset_mid_write");
        waitCk(3);
        XARST_i = 1'b1;
        exp_ram = '0;
        sendBits(8'h0F, 4);
        link.STB_i = 1'b1;
        waitCk(2 * H);
        checkOutput("orphan_frame_ignored", DISP_RAM_o, 128'd0);
        frame_q = '{8'hC5, 8'h99};
        wr_q.push_back('{adr: 4'd5, dat: 8'h99});
        exp_ram[5] = 8'h99;
        applyStimulus();
        checkOutput("after_reset_write", DISP_RAM_o, exp_ram);

        // Reset in the middle of a key read
        $display("[TB] reset mid-read");
        KEY_i = 32'h1234_5678;
        rd_q.push_back(8'h78);
        link.STB_i = 1'b0;
        waitCk(H);
        sendBits(8'h42, 8);
        readKeys(1);
        link.SCLK_i = 1'b0;
        waitCk(H);
        checkOutput("oe_before_reset", 128'(link.DIO_OE_o), 128'd1);
        XARST_i = 1'b0;
        #1;
        checkAllZero("reset_mid_read");
        waitCk(3);
        XARST_i = 1'b1;
        link.SCLK_i = 1'b1;
        waitCk(H);
        link.SCLK_i = 1'b0;
        waitCk(H);
        checkOutput("oe_orphan_read", 128'(link.DIO_OE_o), 128'd0);
        link.SCLK_i = 1'b1;
        waitCk(H);
        link.STB_i = 1'b1;
        waitCk(2 * H);

        KEY_i = 32'hA5C3_3C5A;
        rd_q.push_back(8'h5A);
        rd_q.push_back(8'h3C);
        rd_q.push_back(8'hC3);
        rd_q.push_back(8'hA5);
        link.STB_i = 1'b0;
        waitCk(H);
        sendBits(8'h42, 8);
        readKeys(4);
        link.STB_i = 1'b1;
        waitCk(2 * H);
        checkOutput("final_oe", 128'(link.DIO_OE_o), 128'd0);
        checkOutput("final_writes_done", 128'(wr_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
